// File: rtl/router_reg_gen.sv
// Router input register stage: header capture, FIFO write path with an in-order
// hold queue for fifo_full back-pressure, configurable packet check and error counter.
module router_reg_gen #(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 2,
  parameter int CHK_MODE   = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              pkt_valid,
  input  logic [DATA_W-1:0]                 din,
  input  logic                              fifo_full,
  input  logic                              rst_int_reg,
  input  logic                              detect_add,
  input  logic                              lfd_state,
  input  logic                              ld_state,
  input  logic                              laf_state,
  output logic                              parity_done,
  output logic                              low_pkt_valid,
  output logic                              err,
  output logic [DATA_W-1:0]                 dout,
  output logic                              dout_valid,
  output logic [$clog2(HOLD_DEPTH+1)-1:0]   hold_count,
  output logic                              hold_ovf,
  output logic [ERR_CNT_W-1:0]              err_count
);

  localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

  function automatic logic [DATA_W-1:0] chk_op(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    if (CHK_MODE == 1) chk_op = a + b;
    else               chk_op = a ^ b;
  endfunction

  logic [DATA_W-1:0]    r_header;
  logic [DATA_W-1:0]    r_packet;
  logic [DATA_W-1:0]    r_internal;
  logic                 r_parity_done;
  logic                 r_low_pkt_valid;
  logic                 r_err;
  logic [DATA_W-1:0]    r_dout;
  logic                 r_dout_valid;
  logic                 r_hold_ovf;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [DATA_W-1:0]    r_hold [HOLD_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;

  logic             w_accept;
  logic             w_capture;
  logic             w_fwd;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_direct;
  logic             w_push_req;
  logic             w_drop;
  logic             w_push;
  logic             w_accum;
  logic             w_err_next;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [PTR_W-1:0] w_wr_ptr_inc;

  assign w_accept  = ld_state && pkt_valid;
  assign w_capture = ld_state && !pkt_valid && !r_low_pkt_valid;
  // The check byte travels the same data path as payload.
  assign w_fwd     = w_accept || w_capture;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(HOLD_DEPTH));

  assign w_pop      = !lfd_state && !w_empty && !fifo_full && (ld_state || laf_state);
  assign w_direct   = !lfd_state && w_empty && w_fwd && !fifo_full;
  assign w_push_req = w_fwd && !w_direct;
  // A simultaneous pop frees the slot the push needs, so a full queue only drops without one.
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_push     = w_push_req && !w_drop;
  assign w_accum    = w_accept && !w_drop;

  assign w_err_next   = !rst_int_reg && r_parity_done && (r_internal != r_packet);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(HOLD_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(HOLD_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_header        <= '0;
      r_packet        <= '0;
      r_internal      <= '0;
      r_parity_done   <= 1'b0;
      r_low_pkt_valid <= 1'b0;
      r_err           <= 1'b0;
      r_dout          <= '0;
      r_dout_valid    <= 1'b0;
      r_hold_ovf      <= 1'b0;
      r_err_count     <= '0;
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      for (int i = 0; i < HOLD_DEPTH; i++) r_hold[i] <= '0;
    end else begin
      if (detect_add && pkt_valid) r_header <= din;

      r_dout_valid <= lfd_state || w_pop || w_direct;
      if (lfd_state)     r_dout <= r_header;
      else if (w_pop)    r_dout <= r_hold[r_rd_ptr];
      else if (w_direct) r_dout <= din;

      if (w_push) begin
        r_hold[r_wr_ptr] <= din;
        r_wr_ptr         <= w_wr_ptr_inc;
      end
      if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (w_drop) r_hold_ovf <= 1'b1;

      if (detect_add || rst_int_reg) r_internal <= '0;
      else if (lfd_state)            r_internal <= r_header;
      else if (w_accum)              r_internal <= chk_op(r_internal, din);

      if (w_capture)                      r_packet <= din;
      else if (detect_add || rst_int_reg) r_packet <= '0;

      if (detect_add)     r_parity_done <= 1'b0;
      else if (w_capture) r_parity_done <= 1'b1;

      if (w_capture)        r_low_pkt_valid <= 1'b1;
      else if (rst_int_reg) r_low_pkt_valid <= 1'b0;

      r_err <= w_err_next;
      if (w_err_next && !r_err && (r_err_count != '1)) r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;
  assign dout          = r_dout;
  assign dout_valid    = r_dout_valid;
  assign hold_count    = r_count;
  assign hold_ovf      = r_hold_ovf;
  assign err_count     = r_err_count;

endmodule
